// File: rtl/arbitro_rr.sv
// Registered N-way bus arbiter: round-robin or fixed-priority selection,
// grant locking with a bounded hold time, one-hot grant plus encoded index.
module arbitro_rr #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_num,
    output logic             available
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0]       HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] last, last_n;
    logic [7:0]       hold_cnt, hold_n;
    logic [N-1:0]     grant_n;
    logic [N-1:0]     req_masked;
    logic [IDX_W-1:0] win_req, win_masked;

    // Round-robin scans upward from ptr+1 with wrap; fixed priority from index 0.
    function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] r,
                                              input logic rr,
                                              input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = rr ? (int'(ptr) + 1 + i) % N : i;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign req_masked = req & ~(N'(1) << owner);
    assign win_req    = pick(req, ~mode, last);
    assign win_masked = pick(req_masked, ~mode, last);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = BUSY;
                    owner_n = win_req;
                    last_n  = win_req;
                    hold_n  = 8'd1;
                end
            end
            BUSY: begin
                if (!req[owner]) begin
                    if (|req) begin
                        owner_n = win_req;
                        last_n  = win_req;
                        hold_n  = 8'd1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = 8'd0;
                    end
                end else if (hold_cnt < HOLD_MAX) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    // Expiry: hand over if anyone else waits, otherwise re-grant the owner.
                    owner_n = (|req_masked) ? win_masked : owner;
                    last_n  = owner_n;
                    hold_n  = 8'd1;
                end
            end
            default: begin
                state_n = IDLE;
                hold_n  = 8'd0;
            end
        endcase
        grant_n = (state_n == BUSY) ? (N'(1) << owner_n) : '0;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= LAST_RST;
            hold_cnt  <= 8'd0;
            grant     <= '0;
            grant_num <= '0;
            available <= 1'b1;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            hold_cnt  <= hold_n;
            grant     <= grant_n;
            grant_num <= (state_n == BUSY) ? owner_n : '0;
            available <= (state_n != BUSY);
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr: expected grants are queued as stimulus is
// driven and compared after the following clock edge.
module tb_arbitro_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_a, mode_b;
    logic [3:0] req_a, req_b;
    logic [3:0] grant_a, grant_b;
    logic [1:0] num_a, num_b;
    logic       avail_a, avail_b;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      tag;
        logic [3:0] grant;
        logic [1:0] num;
        logic       avail;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    arbitro_rr #(.N(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .req(req_a),
        .grant(grant_a), .grant_num(num_a), .available(avail_a)
    );

    arbitro_rr #(.N(4), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .req(req_b),
        .grant(grant_b), .grant_num(num_b), .available(avail_b)
    );

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) n = 2'(i);
        return n;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected result, compare after the edge.
    task automatic step(input string tag, input bit sel, input logic [3:0] r,
                        input logic m, input logic [3:0] g);
        exp_t e;
        e.tag   = tag;
        e.grant = g;
        e.num   = enc(g);
        e.avail = (g == 4'b0000);
        if (sel) begin
            req_b  = r;
            mode_b = m;
        end else begin
            req_a  = r;
            mode_a = m;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_scoreboard"}, 4'd0, 4'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_grant"}, sel ? grant_b : grant_a, e.grant);
            check({e.tag, "_num"},   {2'b00, sel ? num_b : num_a}, {2'b00, e.num});
            check({e.tag, "_avail"}, {3'b000, sel ? avail_b : avail_a}, {3'b000, e.avail});
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = 4'b1111;
        mode_a = 1'b0;
        req_b  = 4'b0000;
        mode_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", grant_a, 4'b0000);
        check("rst_num",   {2'b00, num_a}, 4'd0);
        check("rst_avail", {3'b000, avail_a}, 4'd1);

        @(negedge clk) rst_n = 1'b1;
        step("rst_first", 0, 4'b1111, 1'b0, 4'b0001);

        // Round-robin rotation, each owner drops its bit for one cycle.
        step("rr1", 0, 4'b1110, 1'b0, 4'b0010);
        step("rr2", 0, 4'b1101, 1'b0, 4'b0100);
        step("rr3", 0, 4'b1011, 1'b0, 4'b1000);
        step("rr4", 0, 4'b0111, 1'b0, 4'b0001);

        // Fixed priority: 2 holds even when 0 arrives, then 0 wins, then expiry gives 3.
        step("fp_first", 0, 4'b1100, 1'b1, 4'b0100);
        for (int i = 0; i < 3; i++)
            step("fp_hold2", 0, 4'b1101, 1'b1, 4'b0100);
        step("fp_rel2", 0, 4'b1001, 1'b1, 4'b0001);
        for (int i = 0; i < 7; i++)
            step("fp_hold0", 0, 4'b1001, 1'b1, 4'b0001);
        step("fp_expiry", 0, 4'b1001, 1'b1, 4'b1000);

        // Mode switch while index 2 owns; the release decision uses fixed priority.
        step("ms_own2", 0, 4'b0100, 1'b0, 4'b0100);
        step("ms_keep_a", 0, 4'b0111, 1'b1, 4'b0100);
        step("ms_keep_b", 0, 4'b0111, 1'b1, 4'b0100);
        step("ms_fixed", 0, 4'b1011, 1'b1, 4'b0001);

        // Async reset between edges while index 3 owns.
        step("ar_own3", 0, 4'b1000, 1'b0, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant", grant_a, 4'b0000);
        check("ar_avail", {3'b000, avail_a}, 4'd1);
        check("ar_num",   {2'b00, num_a}, 4'd0);
        @(negedge clk) req_a = 4'b1001;
        @(negedge clk) rst_n = 1'b1;
        step("wrap_first", 0, 4'b1001, 1'b0, 4'b0001);
        step("rel_idle",   0, 4'b0000, 1'b0, 4'b0000);
        step("stay_idle",  0, 4'b0000, 1'b0, 4'b0000);

        // Hold expiry with MAX_HOLD=3.
        for (int i = 0; i < 3; i++)
            step("exp_own0", 1, 4'b0011, 1'b0, 4'b0001);
        for (int i = 0; i < 3; i++)
            step("exp_own1", 1, 4'b0011, 1'b0, 4'b0010);
        step("exp_back0", 1, 4'b0011, 1'b0, 4'b0001);
        for (int i = 0; i < 8; i++)
            step("exp_sole", 1, 4'b0001, 1'b0, 4'b0001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Parametrised, registered N-way bus arbiter. It is the sequential successor of the 4-input combinational `arbitro`. It adds round-robin fairness, a selectable fixed-priority mode, and grant locking with a bounded hold time. It sits between N requesting masters and one shared resource, and drives a one-hot grant, the encoded winner index and an idle flag.

## Interface

Parameters:
- `N`, default 4: number of requesters; legal range 2..32.
- `IDX_W`, default `$clog2(N)`: width of `grant_num`; derived, never overridden.
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner may keep the grant; legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `mode`, in, 1: arbitration policy. 0 = round-robin; 1 = fixed priority, with index 0 highest.
- `req`, in, N: request vector; bit i is held high by master i while it wants the resource.
- `grant`, out, N: registered grant; one-hot or all-zero.
- `grant_num`, out, IDX_W: binary index of the set `grant` bit; 0 when `grant` is zero.
- `available`, out, 1: high when `grant` is all-zero, meaning the resource is free.

## Operation

- State machine, 2 states:
  - IDLE: `grant` = 0.
  - BUSY: one owner holds the grant.
- Registered state:
  - `owner`: IDX_W bits.
  - `hold_cnt`: 8 bits, saturating at MAX_HOLD.
  - `last`: IDX_W bits; round-robin pointer, the most recent owner.
- Winner selection (combinational, evaluated at each decision point):
  - mode 0: first set `req` bit scanning from `last+1` upward, wrapping from N-1 to 0.
  - mode 1: lowest-index set `req` bit.
- In IDLE:
  - If `req` = 0, stay in IDLE.
  - Otherwise grant the winner, go to BUSY, set `hold_cnt` = 1, and set `last` = winner.
- In BUSY with `req[owner]` = 1 and `hold_cnt` < MAX_HOLD: keep `grant` unchanged and increment `hold_cnt`.
- In BUSY with `req[owner]` = 0 (release):
  - Select a winner among the current `req`, excluding nothing.
  - If `req` = 0, go to IDLE.
  - Otherwise switch `grant` directly to the winner with no idle gap, and set `hold_cnt` = 1.
- In BUSY with `req[owner]` = 1 and `hold_cnt` = MAX_HOLD (expiry):
  - Select a winner with the owner's bit masked off.
  - If another request exists, switch to it.
  - If the owner is the sole requester, re-grant the owner with `hold_cnt` = 1.
  - Expiry applies in both modes. In mode 1, masking the owner bit guarantees lower-priority requesters progress.
- `last` updates to the new owner on every grant or re-grant.
- `mode` is sampled only at decision points. Changing it mid-hold does not affect the current owner.
- `grant_num` and `available` are decoded from registered state and are glitch-free.

## Timing

- Reset values (asserted asynchronously, immediately):
  - state IDLE
  - `grant` = 0
  - `grant_num` = 0
  - `available` = 1
  - `hold_cnt` = 0
  - `last` = N-1, so index 0 wins the first round-robin decision
- Reset release is synchronous to the next `clk` edge. The first grant is possible on the first edge after `rst_n` rises.
- Latency:
  - Request in cycle t (sampled at edge t+1): grant visible after edge t+1. This is 1 cycle from IDLE.
  - Release: owner drops `req` in cycle t, and the new `grant` (or 0) is visible after edge t+1.
- Maximum continuous ownership is MAX_HOLD cycles while another request is pending.
- Worst-case wait in mode 0 with all requesters active: (N-1)·MAX_HOLD cycles.
- A requester dropping `req` before being granted is never granted.
- `rst_n` asserted mid-grant clears `grant` at once. No partial state survives.
- Wrap-around: after owner N-1, mode 0 scanning starts at index 0.

## Test plan

- **Reset/idle.** Hold `rst_n`=0 with `req`=4'b1111, then release. Required:
  - during reset: `grant`=0, `available`=1.
  - one edge after release: `grant`=4'b0001, `grant_num`=0.
- **Round-robin rotation.** N=4, MAX_HOLD=8, mode 0, `req`=4'b1111; each owner drops its bit for one cycle after its grant. Required: grant sequence 0001 → 0010 → 0100 → 1000 → 0001, with no idle cycle between grants.
- **Hold expiry.** MAX_HOLD=3, `req`=4'b0011 held constant. Required: `grant`=0001 for exactly 3 cycles, then 0010 for 3 cycles, then 0001 again. With `req`=4'b0001 alone, 0001 is re-granted continuously.
- **Fixed priority.** mode 1, `req`=4'b1100, then 4'b1101 mid-hold. Required:
  - `grant`=0100 is held until release or expiry.
  - next decision grants 0001.
  - index 3 is granted only after index 2 releases or on expiry masking.
- **Mode switch mid-hold.** Switch `mode` 0→1 while index 2 owns. Required: index 2 keeps the grant until release or expiry, and the next decision uses fixed priority.
- **Async reset mid-grant and wrap.** Assert `rst_n`=0 between edges while `grant`=1000. Required: `grant`=0 and `available`=1 immediately, without waiting for an edge. After reset, mode 0 with `req`=1001 grants index 0 first.
